// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and data bundle between the key-expansion side, the iterative
// AES inverse cipher, and the downstream decrypt-path buffer.
interface aes_inv_cipher_iter_if #(
    parameter int NR = 10
) ();
    localparam int NK_WORDS = 4 * (NR + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [127:0]               d_in;
    logic [0:NK_WORDS-1][31:0]  key_schedule;
    logic                       out_valid;
    logic                       out_ready;
    logic [127:0]               d_out;
    logic                       busy;

    modport master (
        output in_valid,
        output d_in,
        output key_schedule,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  d_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  d_in,
        input  key_schedule,
        input  out_ready,
        output in_ready,
        output out_valid,
        output d_out,
        output busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one shared inverse-round datapath reused NR
// times per block, with a precomputed encryption key schedule supplied externally.
module aes_inv_cipher_iter #(
    parameter int NR       = 10,
    parameter int NK_WORDS = 4 * (NR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_cipher_iter_if.slave bus
);
    localparam int RND_W = $clog2(NR + 1);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
        if (NK_WORDS != 4 * (NR + 1)) begin : g_bad_nk
            $error("aes_inv_cipher_iter: NK_WORDS is derived from NR and must not be overridden");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    state_e           state_q, state_d;
    logic [127:0]     st_q, st_d;
    logic [127:0]     d_out_q, d_out_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             out_valid_q, busy_q;

    logic [127:0] rk_last, rk_rnd;
    logic [127:0] sr, sb, ak, mc;
    logic         in_ready, accept;

    assign rk_last = {bus.key_schedule[4*NR],   bus.key_schedule[4*NR+1],
                      bus.key_schedule[4*NR+2], bus.key_schedule[4*NR+3]};

    always_comb begin
        rk_rnd = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rnd_q == RND_W'(r)) begin
                rk_rnd = {bus.key_schedule[4*r],   bus.key_schedule[4*r+1],
                          bus.key_schedule[4*r+2], bus.key_schedule[4*r+3]};
            end
        end
    end

    // State byte k sits at bits [127-8k -: 8], row = k%4, column = k/4.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign sr[127-8*gi -: 8] = st_q[127-8*SRC -: 8];
            assign sb[127-8*gi -: 8] = inv_sbox(sr[127-8*gi -: 8]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mc[127-32*gi -: 32] = inv_mix_col(ak[127-32*gi -: 32]);
        end
    endgenerate

    assign ak = sb ^ rk_rnd;

    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        d_out_d = d_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = bus.d_in ^ rk_last;
                    rnd_d   = RND_W'(NR - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // The last round skips InvMixColumns and writes straight to the output register.
                if (rnd_q == '0) begin
                    d_out_d = ak;
                    state_d = DONE;
                end else begin
                    st_d  = mc;
                    rnd_d = rnd_q - RND_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        st_d    = bus.d_in ^ rk_last;
                        rnd_d   = RND_W'(NR - 1);
                        state_d = ROUND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rnd_q       <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rnd_q       <= rnd_d;
            d_out_q     <= d_out_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == ROUND);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.d_out     = d_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES inverse cipher: NR=10/12/14 instances driven with
// known-answer vectors, checked by a queue-based scoreboard and a monitor.
module tb_aes_inv_cipher_iter;
    typedef struct {
        int           k;
        logic [127:0] pt;
    } exp_t;

    typedef struct {
        int k;
        int c;
    } acc_t;

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_14 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K_SP  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT_3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] CT_3  = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] PT_4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT_4  = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk;
    logic rst;
    logic [2:0] iv, ir, ov, ordy, bsy;
    logic [2:0][127:0] din, dout;
    logic [2:0][0:59][31:0] ks_all;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ir_hi [3];
    logic [2:0] seen;
    exp_t exp_q [$];
    acc_t acc_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inst
            localparam int NRG = 10 + 2 * gi;
            localparam int NKW = 4 * (NRG + 1);
            aes_inv_cipher_iter_if #(.NR(NRG)) bus ();
            assign bus.in_valid     = iv[gi];
            assign bus.d_in         = din[gi];
            assign bus.out_ready    = ordy[gi];
            assign bus.key_schedule = ks_all[gi][0:NKW-1];
            assign ir[gi]   = bus.in_ready;
            assign ov[gi]   = bus.out_valid;
            assign dout[gi] = bus.d_out;
            assign bsy[gi]  = bus.busy;
            aes_inv_cipher_iter #(.NR(NRG)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    // ---------------- key expansion (stimulus only) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_key(input int k, input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) ks_all[k][i] = w[i];
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Scoreboard monitor: pops one expected plaintext at each out_valid rise.
    always @(negedge clk) begin
        exp_t e;
        acc_t a;
        if (rst) begin
            seen = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ir[k]) ir_hi[k]++;
                if (iv[k] && ir[k]) acc_q.push_back('{k, cyc});
                if (ov[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    n_cmp++;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output inst%0d: got d_out=%h with no block pending", k, dout[k]);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        if (e.k != k || dout[k] !== e.pt) begin
                            n_fail++;
                            $display("FAIL data inst%0d: got %h expected %h (for inst%0d)", k, dout[k], e.pt, e.k);
                        end else begin
                            $display("ok   data inst%0d: %h", k, dout[k]);
                        end
                        n_cmp++;
                        if (a.k != k || cyc - a.c != 11 + 2 * k) begin
                            n_fail++;
                            $display("FAIL latency inst%0d: got %0d cycles expected %0d", k, cyc - a.c, 11 + 2 * k);
                        end else begin
                            $display("ok   latency inst%0d: %0d cycles", k, cyc - a.c);
                        end
                    end
                end
                if (ov[k] && ordy[k]) seen[k] = 1'b0;
            end
        end
    end

    // Presents one block and waits (bounded) for it to be accepted.
    task automatic send(input int k, input logic [127:0] ct, input logic [127:0] pt,
                        input bit hold, output int acc_cyc);
        din[k] = ct;
        iv[k]  = 1'b1;
        exp_q.push_back('{k, pt});
        acc_cyc = -1;
        for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (ir[k]) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (!hold) iv[k] = 1'b0;
        if (acc_cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout inst%0d: got no accept expected one within 200 cycles", k);
        end
    endtask

    task automatic wait_drain(input int k);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ov[k] && !bsy[k]) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout inst%0d: got busy=%b out_valid=%b expected idle", k, bsy[k], ov[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, a3, h0, t, nov;
        bit got;
        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        din  = '0;
        seen = '0;
        for (int k = 0; k < 3; k++) ir_hi[k] = 0;
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        expand_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
        expand_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("in_reset inst%0d {in_ready,out_valid,busy,d_out}", k),
                {ir[k], ov[k], bsy[k], dout[k]}, {3'b000, 128'h0});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_reset {in_ready,out_valid,busy,d_out}", {ir[0], ov[0], bsy[0], dout[0]}, {3'b100, 128'h0});

        // FIPS-197 C.1, C.2, C.3 known answers
        @(posedge clk);
        #1 ordy = 3'b111;
        send(0, CT_10, PT_C, 1'b0, a);
        @(negedge clk);
        chk("in_round {busy,in_ready}", {bsy[0], ir[0]}, 2'b10);
        wait_drain(0);
        chk("back_to_idle {in_ready,busy,out_valid}", {ir[0], bsy[0], ov[0]}, 3'b100);
        @(posedge clk);
        #1;
        send(1, CT_12, PT_C, 1'b0, a);
        wait_drain(1);
        @(posedge clk);
        #1;
        send(2, CT_14, PT_C, 1'b0, a);
        wait_drain(2);

        // Back-to-back with in_valid held high
        expand_key(0, {K_SP, 128'h0}, 10);
        @(posedge clk);
        #1 h0 = ir_hi[0];
        send(0, CT_1, PT_1, 1'b1, a1);
        send(0, CT_2, PT_2, 1'b1, a2);
        send(0, CT_3, PT_3, 1'b1, a3);
        iv[0] = 1'b0;
        chk("b2b accept spacing 1->2", 256'(a2 - a1), 256'd11);
        chk("b2b accept spacing 2->3", 256'(a3 - a2), 256'd11);
        chk("b2b in_ready high cycles", 256'(ir_hi[0] - h0), 256'd3);
        wait_drain(0);

        // Backpressure, then release together with the next block
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        send(0, CT_4, PT_4, 1'b0, a);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ov[0]) got = 1'b1;
        end
        if (!got) chk("bp out_valid timeout", 256'(ov[0]), 256'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold cyc%0d {out_valid,in_ready,busy,d_out}", i),
                {ov[0], ir[0], bsy[0], dout[0]}, {3'b100, PT_4});
        end
        @(posedge clk);
        #1 t = cyc;
        ordy[0] = 1'b1;
        send(0, CT_B, PT_B, 1'b0, a);
        chk("bp release accepts on same edge", 256'(a - t), 256'd0);
        wait_drain(0);

        // Reset mid-round aborts the block
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        @(posedge clk);
        #1;
        send(0, CT_10, PT_C, 1'b0, a);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset {out_valid,in_ready,busy,d_out}", {ov[0], ir[0], bsy[0], dout[0]}, {3'b010, 128'h0});
        nov = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[0]) nov++;
        end
        chk("aborted block out_valid cycles", 256'(nov), 256'd0);
        @(posedge clk);
        #1;
        send(0, CT_10, PT_C, 1'b0, a);
        wait_drain(0);

        chk("scoreboard empty at end", 256'(exp_q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
